// File: rtl/button_conditioner.sv
// Purpose: synchronise, debounce and edge-detect three active-low buttons into held levels and one-cycle game commands.
// Latency: pin edge to btn* is 2+DEBOUNCE_CYCLES cycles; btn* rise to first moveR/moveL/fire pulse is 1 cycle.
// Backpressure: none; pulses are single-cycle commands that the game logic must take when they appear.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 22780,
  parameter int REPEAT_DELAY    = 6834000,
  parameter int REPEAT_PERIOD   = 2278000,
  parameter int CNT_W           = 23
) (
  input  logic CLK22_78MHZ,
  input  logic reset,
  input  logic pbR,
  input  logic pbL,
  input  logic pbG,
  output logic btnR,
  output logic btnL,
  output logic btnG,
  output logic moveR,
  output logic moveL,
  output logic fire
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LOAD = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} mv_state_t;

  // Bit order everywhere: 0 = right, 1 = left, 2 = fire.
  logic [2:0]       pb_raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       pressed;
  logic [2:0]       btn;
  logic [CNT_W-1:0] db_cnt [3];
  logic             btn_g_q;

  // Move FSMs: index 0 = right, 1 = left.
  mv_state_t        state     [2];
  mv_state_t        state_nxt [2];
  logic [CNT_W-1:0] rpt_cnt     [2];
  logic [CNT_W-1:0] rpt_cnt_nxt [2];
  logic [1:0]       hold;
  logic [1:0]       pulse_nxt;
  logic [1:0]       move_q;

  assign pb_raw  = {pbG, pbL, pbR};
  assign pressed = ~sync2;

  // A direction only counts as held when the opposite one is not, so both-held parks both FSMs.
  assign hold[0] = btn[0] & ~btn[1];
  assign hold[1] = btn[1] & ~btn[0];

  // Two-flop synchroniser; resets to the released (high) pin level.
  always_ff @(posedge CLK22_78MHZ) begin
    if (reset) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= pb_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: a new level must persist DEBOUNCE_CYCLES consecutive cycles before btn follows it.
  always_ff @(posedge CLK22_78MHZ) begin
    if (reset) begin
      btn <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (pressed[i] == btn[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn[i]    <= ~btn[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Fire: one registered pulse on each debounced press, nothing on release.
  always_ff @(posedge CLK22_78MHZ) begin
    if (reset) begin
      btn_g_q <= 1'b0;
      fire    <= 1'b0;
    end else begin
      btn_g_q <= btn[2];
      fire    <= btn[2] & ~btn_g_q;
    end
  end

  // Move FSM state register, repeat counters and registered move pulses.
  always_ff @(posedge CLK22_78MHZ) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state[i]   <= IDLE;
        rpt_cnt[i] <= '0;
      end
      move_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state[i]   <= state_nxt[i];
        rpt_cnt[i] <= rpt_cnt_nxt[i];
      end
      move_q <= pulse_nxt;
    end
  end

  // Move FSM next state: leave IDLE on hold, DELAY hands over to REPEAT when the delay expires.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_nxt[i] = state[i];
      case (state[i])
        IDLE:    if (hold[i]) state_nxt[i] = DELAY;
        DELAY:   if (!hold[i]) state_nxt[i] = IDLE;
                 else if (rpt_cnt[i] == '0) state_nxt[i] = REPEAT;
        REPEAT:  if (!hold[i]) state_nxt[i] = IDLE;
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  // Move FSM outputs: pulse on entry and whenever the counter hits 0; counter saturates at 0.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      pulse_nxt[i]   = 1'b0;
      rpt_cnt_nxt[i] = rpt_cnt[i];
      case (state[i])
        IDLE: begin
          if (hold[i]) begin
            pulse_nxt[i]   = 1'b1;
            rpt_cnt_nxt[i] = RD_LOAD;
          end else begin
            rpt_cnt_nxt[i] = '0;
          end
        end
        DELAY, REPEAT: begin
          if (!hold[i]) begin
            rpt_cnt_nxt[i] = '0;
          end else if (rpt_cnt[i] == '0) begin
            pulse_nxt[i]   = 1'b1;
            rpt_cnt_nxt[i] = RP_LOAD;
          end else begin
            rpt_cnt_nxt[i] = rpt_cnt[i] - CNT_W'(1);
          end
        end
        default: rpt_cnt_nxt[i] = '0;
      endcase
    end
  end

  assign btnR  = btn[0];
  assign btnL  = btn[1];
  assign btnG  = btn[2];
  assign moveR = move_q[0];
  assign moveL = move_q[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
// Expected pulse cycles are queued when stimulus is issued; a negedge monitor pops and compares them.
module tb_button_conditioner;

  logic clk;
  logic reset;
  logic pbR, pbL, pbG;
  logic btnR, btnL, btnG;
  logic moveR, moveL, fire;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int k;
  logic rnd_mode = 1'b0;
  logic g_d1 = 1'b0;
  logic g_d2 = 1'b0;

  int exp_r[$];
  int exp_l[$];
  int exp_g[$];

  // Hand-computed pulse offsets from the pin edge at cycle k.
  int s3_r[9] = '{7, 15, 18, 21, 24, 27, 30, 33, 36};
  int s4_r[4] = '{7, 15, 18, 21};
  int s4_l[4] = '{37, 45, 48, 51};
  int s5_l[7] = '{7, 15, 18, 28, 36, 39, 42};

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(3),
    .CNT_W(23)
  ) dut (
    .CLK22_78MHZ(clk),
    .reset(reset),
    .pbR(pbR),
    .pbL(pbL),
    .pbG(pbG),
    .btnR(btnR),
    .btnL(btnL),
    .btnG(btnG),
    .moveR(moveR),
    .moveL(moveL),
    .fire(fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_at(input int kind, input int c);
    case (kind)
      0: exp_r.push_back(c);
      1: exp_l.push_back(c);
      default: exp_g.push_back(c);
    endcase
  endtask

  task automatic sb_pop(input int kind, input string nm);
    int e;
    int sz;
    case (kind)
      0: sz = exp_r.size();
      1: sz = exp_l.size();
      default: sz = exp_g.size();
    endcase
    total++;
    if (sz == 0) begin
      bad++;
      $display("FAIL %s_unexpected: pulse at cycle %0d, none required", nm, cyc);
    end else begin
      case (kind)
        0: e = exp_r.pop_front();
        1: e = exp_l.pop_front();
        default: e = exp_g.pop_front();
      endcase
      if (e != cyc) begin
        bad++;
        $display("FAIL %s_time: pulse at cycle %0d, required cycle %0d", nm, cyc, e);
      end
    end
  endtask

  task automatic chk_empty(input string nm);
    chk({nm, "_moveR_missing"}, exp_r.size(), 0);
    chk({nm, "_moveL_missing"}, exp_l.size(), 0);
    chk({nm, "_fire_missing"}, exp_g.size(), 0);
    exp_r.delete();
    exp_l.delete();
    exp_g.delete();
  endtask

  // Monitor: exclusivity every cycle; scoreboard pops in directed mode, fire/btnG edge relation in random mode.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      total++;
      if (moveR === 1'b1 && moveL === 1'b1) begin
        bad++;
        $display("FAIL move_exclusive: moveR=1 moveL=1 at cycle %0d, required not both", cyc);
      end
      if (rnd_mode) begin
        total++;
        if (fire !== (g_d1 & ~g_d2)) begin
          bad++;
          $display("FAIL fire_edge: fire=%0b at cycle %0d, required %0b", fire, cyc, g_d1 & ~g_d2);
        end
      end else begin
        if (moveR === 1'b1) sb_pop(0, "moveR");
        if (moveL === 1'b1) sb_pop(1, "moveL");
        if (fire === 1'b1)  sb_pop(2, "fire");
      end
    end
    g_d2 = g_d1;
    g_d1 = btnG;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pbR = 1'b1;
    pbL = 1'b1;
    pbG = 1'b1;
    tick(3);
    chk("rst_btnR", btnR, 0);
    chk("rst_btnL", btnL, 0);
    chk("rst_btnG", btnG, 0);
    chk("rst_moveR", moveR, 0);
    chk("rst_moveL", moveL, 0);
    chk("rst_fire", fire, 0);
    reset = 1'b0;
    tick(5);

    // 1: fire press held 20 cycles.
    k = cyc;
    pbG = 1'b0;
    expect_at(2, k + 7);
    tick(5);  chk("s1_btnG_before", btnG, 0);
    tick(1);  chk("s1_btnG_rise", btnG, 1);
    tick(1);  chk("s1_fire_high", fire, 1);
    tick(1);  chk("s1_fire_low", fire, 0);
    tick(12); chk("s1_btnG_held", btnG, 1);
    pbG = 1'b1;
    tick(10); chk("s1_btnG_released", btnG, 0);
    chk_empty("s1");

    // 2: 3-cycle glitch on pbR must be rejected.
    k = cyc;
    pbR = 1'b0;
    tick(3);
    pbR = 1'b1;
    tick(3); chk("s2_btnR_a", btnR, 0);
    tick(6); chk("s2_btnR_b", btnR, 0);
    chk_empty("s2");

    // 3: right held 30 cycles with auto-repeat.
    k = cyc;
    pbR = 1'b0;
    foreach (s3_r[i]) expect_at(0, k + s3_r[i]);
    tick(6);  chk("s3_btnR_rise", btnR, 1);
    tick(24);
    pbR = 1'b1;
    tick(6);  chk("s3_btnR_fall", btnR, 0);
    tick(6);
    chk_empty("s3");

    // 4: right held, left joins after the second repeat, right released first.
    k = cyc;
    pbR = 1'b0;
    foreach (s4_r[i]) expect_at(0, k + s4_r[i]);
    foreach (s4_l[i]) expect_at(1, k + s4_l[i]);
    tick(16);
    pbL = 1'b0;
    tick(6);  chk("s4_btnL_rise", btnL, 1);
    tick(8);
    pbR = 1'b1;
    tick(6);  chk("s4_btnR_fall", btnR, 0);
    tick(10);
    pbL = 1'b1;
    tick(14);
    chk_empty("s4");

    // 5: left held, reset pulsed for 2 cycles mid-repeat.
    k = cyc;
    pbL = 1'b0;
    foreach (s5_l[i]) expect_at(1, k + s5_l[i]);
    tick(19);
    reset = 1'b1;
    tick(1);
    chk("s5_rst_btnR", btnR, 0);
    chk("s5_rst_btnL", btnL, 0);
    chk("s5_rst_btnG", btnG, 0);
    chk("s5_rst_moveR", moveR, 0);
    chk("s5_rst_moveL", moveL, 0);
    chk("s5_rst_fire", fire, 0);
    tick(1);
    chk("s5_rst2_btnL", btnL, 0);
    chk("s5_rst2_moveL", moveL, 0);
    reset = 1'b0;
    tick(5);  chk("s5_btnL_before", btnL, 0);
    tick(1);  chk("s5_btnL_rise", btnL, 1);
    tick(10);
    pbL = 1'b1;
    tick(15);
    chk_empty("s5");

    // 6: random pin activity on all three buttons.
    rnd_mode = 1'b1;
    fork
      begin
        int w;
        for (int n = 0; n < 2000; n += w) begin
          w = $urandom_range(1, 10);
          pbR = ~pbR;
          tick(w);
        end
      end
      begin
        int w;
        for (int n = 0; n < 2000; n += w) begin
          w = $urandom_range(1, 10);
          pbL = ~pbL;
          tick(w);
        end
      end
      begin
        int w;
        for (int n = 0; n < 2000; n += w) begin
          w = $urandom_range(1, 10);
          pbG = ~pbG;
          tick(w);
        end
      end
    join
    pbR = 1'b1;
    pbL = 1'b1;
    pbG = 1'b1;
    tick(20);
    rnd_mode = 1'b0;
    chk("s6_btnR_idle", btnR, 0);
    chk("s6_btnL_idle", btnL, 0);
    chk("s6_btnG_idle", btnG, 0);
    tick(5);
    chk_empty("s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
